// File: rtl/melody_seq_if.sv
// melody_seq_if: player controls and buzzer PWM generator drive of the melody sequencer.
interface melody_seq_if;
    logic        start;
    logic        stop;
    logic        loop_en;
    logic [1:0]  vol;
    logic [31:0] counter_arr;
    logic [31:0] counter_ccr;
    logic        pwm_gen_en;
    logic        busy;
    logic [3:0]  note_idx;
    logic        done;
    modport master (
        output start, stop, loop_en, vol,
        input  counter_arr, counter_ccr, pwm_gen_en, busy, note_idx, done
    );
    modport slave (
        input  start, stop, loop_en, vol,
        output counter_arr, counter_ccr, pwm_gen_en, busy, note_idx, done
    );
endinterface

// File: rtl/melody_seq.sv
// melody_seq: tempo-timed note ROM player driving the buzzer PWM generator period, compare and enable.
module melody_seq #(
    parameter int BEAT_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 500_000,
    parameter int SONG_LEN    = 16
) (
    input logic          sys_clk,
    input logic          sys_rst_n,
    melody_seq_if.slave  mel
);
    typedef enum logic [2:0] {IDLE, LOAD, NOTE, GAP, DONE} state_t;
    localparam logic [31:0] PERIOD [8] = '{32'd0, 32'd190840, 32'd170068, 32'd151515,
                                           32'd143266, 32'd127551, 32'd113636, 32'd101214};
    // {code, dur}: do..si, high do (two beats), rest, then end markers
    localparam logic [5:0] SONG [16] = '{6'd4, 6'd8, 6'd12, 6'd16, 6'd20, 6'd24, 6'd28, 6'd33,
                                         6'd0, 6'd60, 6'd60, 6'd60, 6'd60, 6'd60, 6'd60, 6'd60};
    state_t      state_q;
    logic [3:0]  idx_q;
    logic [31:0] arr_q, ccr_q;
    logic        en_q, busy_q, done_q;
    logic [26:0] cnt_q;
    logic [5:0]  entry;
    logic [3:0]  code;
    logic [31:0] base, arr_d, ccr_d;
    logic [26:0] cnt_d;
    always_comb begin
        entry = SONG[idx_q];
        code  = entry[5:2];
        base  = PERIOD[code[3] ? code[2:0] + 3'd1 : code[2:0]];
        arr_d = code == 4'd0 ? 32'd1 : code[3] ? base >> 1 : base;
        ccr_d = arr_d >> ({1'b0, mel.vol} + 3'd1);
        cnt_d = 27'(BEAT_CYCLES) * ({25'd0, entry[1:0]} + 27'd1) - 27'd1;
    end
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            arr_q   <= 32'd1;
            ccr_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (mel.stop) begin
                state_q <= IDLE;
                idx_q   <= '0;
                arr_q   <= 32'd1;
                ccr_q   <= '0;
                en_q    <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (mel.start) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                        idx_q   <= '0;
                    end
                    LOAD: if (code == 4'd15) begin
                        if (mel.loop_en) idx_q <= '0;
                        else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            arr_q   <= 32'd1;
                            ccr_q   <= '0;
                        end
                    end else begin
                        state_q <= NOTE;
                        arr_q   <= arr_d;
                        ccr_q   <= ccr_d;
                        en_q    <= code != 4'd0;
                        cnt_q   <= cnt_d;
                    end
                    NOTE: if (cnt_q == '0) begin
                        state_q <= GAP;
                        en_q    <= 1'b0;
                        cnt_q   <= 27'(GAP_CYCLES - 1);
                    end else cnt_q <= cnt_q - 27'd1;
                    // the last ROM slot ends the song even without an end marker
                    GAP: if (cnt_q != '0) cnt_q <= cnt_q - 27'd1;
                    else if (idx_q != 4'(SONG_LEN - 1)) begin
                        idx_q   <= idx_q + 4'd1;
                        state_q <= LOAD;
                    end else if (mel.loop_en) begin
                        idx_q   <= '0;
                        state_q <= LOAD;
                    end else begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        arr_q   <= 32'd1;
                        ccr_q   <= '0;
                    end
                    DONE: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        idx_q   <= '0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
    assign mel.counter_arr = arr_q;
    assign mel.counter_ccr = ccr_q;
    assign mel.pwm_gen_en  = en_q;
    assign mel.busy        = busy_q;
    assign mel.note_idx    = idx_q;
    assign mel.done        = done_q;
endmodule

// File: tb/tb_melody_seq.sv
// tb_melody_seq: directed scenarios checked against a cycle-queue model of the song player.
module tb_melody_seq;
    localparam int BEAT = 20;
    localparam int GAP  = 4;
    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    melody_seq_if mel();
    melody_seq #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .mel(mel)
    );
    always #5 sys_clk = ~sys_clk;

    int tests = 0;
    int fails = 0;
    int shown = 0;

    typedef struct packed {
        logic [31:0] arr;
        logic [31:0] ccr;
        logic        en;
        logic        busy;
        logic        done;
        logic [3:0]  idx;
    } out_t;
    localparam out_t IDLE_O = '{arr: 32'd1, ccr: 32'd0, en: 1'b0, busy: 1'b0, done: 1'b0, idx: 4'd0};

    int song_code [16] = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 15, 15, 15, 15, 15, 15, 15};
    int song_dur  [16] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    int tone [8] = '{0, 190840, 170068, 151515, 143266, 127551, 113636, 101214};

    // Model: expected outputs after each edge, queued note by note when a note is decoded.
    out_t cur;
    out_t q[$];
    bit active, ending, after_gap;
    int idx;
    logic [31:0] last_arr, last_ccr;

    function automatic out_t rec(input logic [31:0] a, input logic [31:0] c, input logic e,
                                 input logic d, input int i);
        out_t r;
        r.arr = a; r.ccr = c; r.en = e; r.busy = 1'b1; r.done = d; r.idx = 4'(i);
        return r;
    endfunction

    task automatic finish_pass();
        if (mel.loop_en) begin
            idx = 0;
            q.push_back(rec(last_arr, last_ccr, 1'b0, 1'b0, 0));
        end else begin
            q.push_back(rec(32'd1, 32'd0, 1'b0, 1'b1, idx));
            ending = 1;
        end
    endtask

    task automatic step();
        int c, per, ccr;
        if (after_gap) begin
            after_gap = 0;
            if (idx == 15) finish_pass();
            else begin
                idx++;
                q.push_back(rec(last_arr, last_ccr, 1'b0, 1'b0, idx));
            end
        end else if (song_code[idx] == 15) finish_pass();
        else begin
            c = song_code[idx];
            per = c == 0 ? 1 : c < 8 ? tone[c] : tone[c - 7] / 2;
            ccr = per >> (1 + mel.vol);
            last_arr = per;
            last_ccr = ccr;
            repeat ((song_dur[idx] + 1) * BEAT) q.push_back(rec(per, ccr, c != 0, 1'b0, idx));
            repeat (GAP) q.push_back(rec(per, ccr, 1'b0, 1'b0, idx));
            after_gap = 1;
        end
    endtask

    initial begin
        cur = IDLE_O;
        forever begin
            @(posedge sys_clk or negedge sys_rst_n);
            if (!sys_rst_n || mel.stop) begin
                q.delete();
                active = 0; ending = 0; after_gap = 0;
            end else if (!active) begin
                if (mel.start) begin
                    active = 1; idx = 0; last_arr = 1; last_ccr = 0;
                    q.push_back(rec(32'd1, 32'd0, 1'b0, 1'b0, 0));
                end
            end else if (q.size() == 0) begin
                if (ending) begin
                    active = 0; ending = 0;
                end else step();
            end
            cur = q.size() != 0 ? q.pop_front() : IDLE_O;
        end
    end

    initial begin
        out_t act;
        forever begin
            @(negedge sys_clk);
            act = {mel.counter_arr, mel.counter_ccr, mel.pwm_gen_en, mel.busy, mel.done, mel.note_idx};
            tests++;
            if (act !== cur) begin
                fails++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL model t=%0t: got arr=%0d ccr=%0d en=%b busy=%b done=%b idx=%0d, expected arr=%0d ccr=%0d en=%b busy=%b done=%b idx=%0d",
                             $time, act.arr, act.ccr, act.en, act.busy, act.done, act.idx,
                             cur.arr, cur.ccr, cur.en, cur.busy, cur.done, cur.idx);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_arr"}, mel.counter_arr, 1);
        chk({name, "_ccr"}, mel.counter_ccr, 0);
        chk({name, "_en"}, 32'(mel.pwm_gen_en), 0);
        chk({name, "_busy"}, 32'(mel.busy), 0);
        chk({name, "_idx"}, 32'(mel.note_idx), 0);
        chk({name, "_done"}, 32'(mel.done), 0);
    endtask

    task automatic pulse_start();
        @(negedge sys_clk); mel.start = 1'b1;
        @(negedge sys_clk); mel.start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge sys_clk); mel.stop = 1'b1;
        @(negedge sys_clk); mel.stop = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, dones, done_at, hi7, sil8, starts;
        logic prev_en;
        mel.start = 1'b0; mel.stop = 1'b0; mel.loop_en = 1'b0; mel.vol = 2'd0;
        repeat (2) @(negedge sys_clk);
        chk_idle("reset");
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // basic start, note timing, then stop mid-note
        pulse_start();
        chk("load_busy", 32'(mel.busy), 1);
        chk("load_en", 32'(mel.pwm_gen_en), 0);
        @(negedge sys_clk);
        chk("first_en", 32'(mel.pwm_gen_en), 1);
        chk("first_arr", mel.counter_arr, 190840);
        chk("first_ccr", mel.counter_ccr, 95420);
        chk("first_idx", 32'(mel.note_idx), 0);
        n = 0;
        while (mel.pwm_gen_en === 1'b1 && n < 200) begin n++; @(negedge sys_clk); end
        chk("note0_len", n, 20);
        n = 0;
        while (mel.pwm_gen_en === 1'b0 && n < 200) begin n++; @(negedge sys_clk); end
        chk("gap0_len", n, 5);
        chk("note1_arr", mel.counter_arr, 170068);
        pulse_stop();
        chk_idle("stop");
        repeat (3) @(negedge sys_clk);
        chk("stop_no_done", 32'(mel.done), 0);

        // full song without looping
        pulse_start();
        n = 0; dones = 0; done_at = -1; hi7 = 0; sil8 = 0;
        while (mel.busy === 1'b1 && n < 1000) begin
            if (mel.done) begin dones++; done_at = n; end
            if (mel.pwm_gen_en && mel.counter_arr == 95420) hi7++;
            if (mel.note_idx == 4'd8 && !mel.pwm_gen_en && mel.counter_arr == 1) sil8++;
            n++;
            @(negedge sys_clk);
        end
        chk("song_busy_cycles", n, 247);
        chk("song_dones", dones, 1);
        chk("song_done_last", done_at, 246);
        chk("entry7_high", hi7, 40);
        chk("entry8_silent", sil8, 24);

        // volume sampled only at LOAD
        mel.vol = 2'd3;
        pulse_start();
        @(negedge sys_clk);
        chk("vol3_ccr", mel.counter_ccr, 11927);
        repeat (5) @(negedge sys_clk);
        mel.vol = 2'd0;
        repeat (3) @(negedge sys_clk);
        chk("vol_mid_hold", mel.counter_ccr, 11927);
        n = 0;
        while (mel.counter_arr !== 32'd170068 && n < 100) begin n++; @(negedge sys_clk); end
        chk("vol0_ccr", mel.counter_ccr, 85034);
        pulse_stop();

        // looping: three passes, no done
        mel.loop_en = 1'b1;
        pulse_start();
        n = 0; starts = 0; dones = 0; prev_en = 1'b0; hi7 = 0;
        while (n < 738) begin
            if (mel.pwm_gen_en && !prev_en && mel.note_idx == 4'd0 && mel.counter_arr == 190840) starts++;
            if (mel.done) dones++;
            if (!mel.busy) hi7++;
            prev_en = mel.pwm_gen_en;
            n++;
            @(negedge sys_clk);
        end
        chk("loop_starts", starts, 3);
        chk("loop_dones", dones, 0);
        chk("loop_idle", hi7, 0);
        pulse_stop();
        mel.loop_en = 1'b0;

        // start and stop together while idle
        @(negedge sys_clk); mel.start = 1'b1; mel.stop = 1'b1;
        @(negedge sys_clk); mel.start = 1'b0; mel.stop = 1'b0;
        chk("startstop_busy", 32'(mel.busy), 0);
        repeat (3) @(negedge sys_clk);
        chk("startstop_busy_later", 32'(mel.busy), 0);

        // asynchronous reset mid-gap
        pulse_start();
        @(negedge sys_clk);
        n = 0;
        while (mel.pwm_gen_en === 1'b1 && n < 200) begin n++; @(negedge sys_clk); end
        @(negedge sys_clk);
        chk("gap_arr_hold", mel.counter_arr, 190840);
        #2 sys_rst_n = 1'b0;
        #1 chk_idle("async_rst");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        // start while busy is ignored
        pulse_start();
        n = 0;
        repeat (3) begin n++; @(negedge sys_clk); end
        mel.start = 1'b1;
        @(negedge sys_clk);
        n++;
        mel.start = 1'b0;
        while (mel.note_idx === 4'd0 && n < 200) begin n++; @(negedge sys_clk); end
        chk("busy_start_span", n, 25);
        chk("busy_start_idx", 32'(mel.note_idx), 1);
        pulse_stop();
        repeat (2) @(negedge sys_clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/melody_seq.md
Name: melody_seq

Overview:
- Upstream sequencer for the buzzer PWM generator. Plays a fixed note ROM with per-note durations, silent gaps between notes, selectable volume and optional looping.
- Drives the generator's counter_arr, counter_ccr and pwm_gen_en inputs directly.
- Replaces the free-running pitch stepper with a start/stop-controlled, tempo-timed player.

Parameters:
- BEAT_CYCLES, 12_500_000: clock cycles per beat (250 ms at 50 MHz).
- GAP_CYCLES, 500_000: silent cycles inserted after each note (10 ms).
- SONG_LEN, 16: ROM depth. Index width is 4 bits.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst_n  in  1  reset.
- start  in  1  one-cycle pulse; begins playback from entry 0 when idle.
- stop  in  1  one-cycle pulse; aborts playback.
- loop_en  in  1  1 = restart at entry 0 on end marker.
- vol  in  2  duty select, sampled in LOAD only.
- counter_arr  out  32  PWM period to generator.
- counter_ccr  out  32  PWM compare value to generator.
- pwm_gen_en  out  1  generator enable.
- busy  out  1  high in any state except IDLE.
- note_idx  out  4  ROM index currently playing.
- done  out  1  one-cycle pulse at natural end of song.

Behaviour:
- Reset is sys_rst_n, asynchronous, active-low. Clock is sys_clk. All outputs are registered.
- Reset values: counter_arr=1, counter_ccr=0, pwm_gen_en=0, busy=0, note_idx=0, done=0. State is IDLE.
- ROM entry format is {code[3:0], dur[1:0]}.
  - Note length = (dur+1) beats.
  - code 0 = rest: arr=1, ccr=0, en=0 for the note time.
  - code 1..7 = do..si periods: 190840, 170068, 151515, 143266, 127551, 113636, 101214.
  - code 8..14 = codes 1..7 period >>1 (high octave).
  - code 15 = end marker.
- ROM contents:
  - Entries 0..6: codes 1..7, dur 0.
  - Entry 7: code 8, dur 1.
  - Entry 8: code 0, dur 0.
  - Entry 9: code 15.
  - Entries 10..15: code 15.
- Volume: counter_ccr = counter_arr >> (1+vol). vol 0 = 50%, 1 = 25%, 2 = 12.5%, 3 = 6.25%.
- FSM states: IDLE, LOAD, NOTE, GAP, DONE.
- IDLE:
  - arr=1, ccr=0, en=0, busy=0.
  - start → LOAD with note_idx=0.
- LOAD (exactly 1 cycle, en=0):
  - Decode ROM[note_idx].
  - code 15 and loop_en=1 → note_idx=0, stay LOAD.
  - code 15 and loop_en=0 → DONE.
  - Otherwise register arr/ccr/en and duration counter, then → NOTE.
- NOTE:
  - en=1 (0 for rest) for exactly (dur+1)*BEAT_CYCLES cycles, then → GAP.
- GAP:
  - en=0, arr/ccr hold, for exactly GAP_CYCLES cycles.
  - If note_idx=SONG_LEN-1, treat as end marker (same loop/DONE rule).
  - Otherwise note_idx+1 → LOAD.
- DONE:
  - done=1 for one cycle, arr=1, ccr=0, then → IDLE.
- Latency:
  - start sampled at edge k → busy=1 and LOAD at k+1 → pwm_gen_en=1 with valid arr/ccr at k+2.
  - Observed silence between consecutive notes = GAP_CYCLES+1 cycles (GAP + LOAD).
- stop:
  - Has priority over everything, including a simultaneous start.
  - Next edge → IDLE with en=0, arr=1, ccr=0, busy=0, note_idx=0. No done pulse.
- start while busy: ignored.
- Changes to vol or loop_en mid-note do not affect the current note. loop_en is evaluated only at end-of-song decision points.
- Duration counter is 27 bits wide; the maximum 4*BEAT_CYCLES must fit.
- Reset asserted mid-note: all outputs go to reset values immediately (asynchronously).

Test Plan:
- Bench parameters: BEAT_CYCLES=20, GAP_CYCLES=4.
- Basic start: start pulse, vol=0 → two edges later en=1, arr=190840, ccr=95420, note_idx=0. en high exactly 20 cycles, then low 5 cycles, then arr=170068.
- Full song, loop_en=0:
  - Entry 7 plays arr=95420 for 40 cycles.
  - Entry 8 is silent for 20 cycles with arr=1.
  - done pulses once, busy falls the cycle after done.
  - Total busy time matches the ROM sum.
- Volume: vol=3 at first LOAD → ccr=190840>>4=11927. Change vol to 0 mid-note → ccr unchanged until next LOAD (170068>>1=85034).
- Loop: loop_en=1 → after entry 8 gap, LOAD sees code 15. Next note is entry 0 (arr=190840), no done pulse. Repeats for 3 passes.
- Stop and start: stop mid-NOTE → next cycle en=0, arr=1, ccr=0, busy=0, no done. Start and stop in the same cycle while IDLE → remains IDLE.
- Reset and re-start: assert sys_rst_n low mid-GAP → outputs at reset values immediately. Start while busy → ignored, note_idx sequence unaffected.
